// File: rtl/arf_pkg.sv
// Shared types and the fixed 28-op schedule for the resource-shared ARF evaluator.
package arf_pkg;

  localparam int unsigned N_OPS = 28;

  typedef enum logic {OP_MUL, OP_ADD} op_kind_t;

  typedef enum logic [1:0] {SRC_R, SRC_X, SRC_S, SRC_C} src_t;

  typedef struct packed {
    src_t       src;
    logic [4:0] idx;
  } opnd_t;

  typedef struct packed {
    op_kind_t   kind;
    opnd_t      src_a;
    opnd_t      src_b;
    logic [4:0] dst;
  } op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_DONE} state_t;

  // Result registers are numbered by op: op n writes slot n-1.
  function automatic opnd_t rr(input int unsigned n);
    return '{SRC_R, 5'(n - 1)};
  endfunction

  function automatic opnd_t rx(input int unsigned i);
    return '{SRC_X, 5'(i)};
  endfunction

  function automatic opnd_t rs(input int unsigned i);
    return '{SRC_S, 5'(i)};
  endfunction

  function automatic opnd_t rc(input int unsigned i);
    return '{SRC_C, 5'(i)};
  endfunction

  function automatic op_t mk(input op_kind_t k, input opnd_t a, input opnd_t b);
    return '{k, a, b, 5'd0};
  endfunction

  function automatic op_t op_rom(input logic [4:0] n);
    op_t o;
    case (n)
      5'd1:    o = mk(OP_MUL, rx(0),  rx(1));
      5'd2:    o = mk(OP_MUL, rx(2),  rx(3));
      5'd3:    o = mk(OP_MUL, rx(4),  rx(5));
      5'd4:    o = mk(OP_MUL, rx(6),  rx(7));
      5'd5:    o = mk(OP_MUL, rx(8),  rx(9));
      5'd6:    o = mk(OP_MUL, rx(10), rx(11));
      5'd7:    o = mk(OP_MUL, rx(12), rx(13));
      5'd8:    o = mk(OP_MUL, rx(14), rx(15));
      5'd9:    o = mk(OP_ADD, rr(1),  rr(2));
      5'd10:   o = mk(OP_ADD, rr(3),  rr(4));
      5'd11:   o = mk(OP_ADD, rr(5),  rr(6));
      5'd12:   o = mk(OP_ADD, rr(7),  rr(8));
      5'd13:   o = mk(OP_ADD, rr(10), rs(0));
      5'd14:   o = mk(OP_ADD, rr(11), rs(1));
      5'd15:   o = mk(OP_MUL, rr(13), rc(0));
      5'd16:   o = mk(OP_MUL, rr(14), rc(1));
      5'd17:   o = mk(OP_MUL, rr(13), rc(2));
      5'd18:   o = mk(OP_MUL, rr(14), rc(3));
      5'd19:   o = mk(OP_ADD, rr(15), rr(16));
      5'd20:   o = mk(OP_ADD, rr(17), rr(18));
      5'd21:   o = mk(OP_MUL, rr(19), rc(4));
      5'd22:   o = mk(OP_MUL, rr(20), rc(5));
      5'd23:   o = mk(OP_MUL, rr(19), rc(6));
      5'd24:   o = mk(OP_MUL, rr(20), rc(7));
      5'd25:   o = mk(OP_ADD, rr(21), rr(22));
      5'd26:   o = mk(OP_ADD, rr(23), rr(24));
      5'd27:   o = mk(OP_ADD, rr(9),  rr(25));
      5'd28:   o = mk(OP_ADD, rr(12), rr(26));
      default: o = mk(OP_ADD, rr(1),  rr(1));
    endcase
    o.dst = n - 5'd1;
    return o;
  endfunction

endpackage

// File: rtl/arf_mul_pipe.sv
// Shared signed fixed-point multiplier: product, pipeline, shift by FRAC, fit to W.
module arf_mul_pipe #(
  parameter int W       = 16,
  parameter int FRAC    = 8,
  parameter int MUL_LAT = 2,
  parameter int SAT     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] res,
  output logic                ovf
);

  logic signed [2*W-1:0] ae, be, prod, prod_l, sh;

  assign ae   = {{W{a[W-1]}}, a};
  assign be   = {{W{b[W-1]}}, b};
  assign prod = ae * be;

  // MUL_LAT-1 internal stages; the caller's result write closes the last cycle.
  generate
    if (MUL_LAT == 1) begin : g_comb
      assign prod_l = prod;
    end else begin : g_pipe
      logic signed [2*W-1:0] stg [MUL_LAT-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < unsigned'(MUL_LAT - 1); i++) stg[i] <= '0;
        end else begin
          stg[0] <= prod;
          for (int unsigned i = 1; i < unsigned'(MUL_LAT - 1); i++) stg[i] <= stg[i-1];
        end
      end
      assign prod_l = stg[MUL_LAT-2];
    end
  endgenerate

  always_comb begin
    sh  = prod_l >>> FRAC;
    ovf = !((&sh[2*W-1:W-1]) || !(|sh[2*W-1:W-1]));
    res = sh[W-1:0];
    if (ovf && SAT != 0) res = sh[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/arf_sched.sv
// ARF dataflow graph evaluated serially on one shared multiplier and one adder,
// sequenced by the op ROM, behind valid/ready job and result handshakes.
module arf_sched
  import arf_pkg::*;
#(
  parameter int W       = 16,
  parameter int FRAC    = 8,
  parameter int MUL_LAT = 2,
  parameter int SAT     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*W-1:0] x,
  input  logic [2*W-1:0]  s,
  input  logic [8*W-1:0]  c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    y0,
  output logic [W-1:0]    y1,
  output logic            ovf
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic signed [W-1:0] x_q [16];
  logic signed [W-1:0] s_q [2];
  logic signed [W-1:0] c_q [8];
  logic signed [W-1:0] r   [N_OPS];

  state_t              state;
  logic [4:0]          op_cnt;
  logic [CW-1:0]       cyc;
  op_t                 cur;
  logic signed [W-1:0] opa, opb, mul_res, add_res, res;
  logic [W:0]          sum;
  logic                mul_ovf, add_ovf, res_ovf, wr;

  always_comb begin
    cur = op_rom(op_cnt);
    opa = '0;
    opb = '0;
    case (cur.src_a.src)
      SRC_R:   opa = r[cur.src_a.idx];
      SRC_X:   opa = x_q[cur.src_a.idx[3:0]];
      SRC_S:   opa = s_q[cur.src_a.idx[0]];
      default: opa = c_q[cur.src_a.idx[2:0]];
    endcase
    case (cur.src_b.src)
      SRC_R:   opb = r[cur.src_b.idx];
      SRC_X:   opb = x_q[cur.src_b.idx[3:0]];
      SRC_S:   opb = s_q[cur.src_b.idx[0]];
      default: opb = c_q[cur.src_b.idx[2:0]];
    endcase
  end

  arf_mul_pipe #(.W(W), .FRAC(FRAC), .MUL_LAT(MUL_LAT), .SAT(SAT)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (opa),
    .b   (opb),
    .res (mul_res),
    .ovf (mul_ovf)
  );

  always_comb begin
    sum     = {opa[W-1], opa} + {opb[W-1], opb};
    add_ovf = sum[W] ^ sum[W-1];
    add_res = sum[W-1:0];
    if (add_ovf && SAT != 0) add_res = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    res     = (cur.kind == OP_MUL) ? mul_res : add_res;
    res_ovf = (cur.kind == OP_MUL) ? mul_ovf : add_ovf;
    wr      = (state == ST_EXEC) && (cur.kind == OP_ADD || cyc == CW'(MUL_LAT - 1));
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      for (int unsigned k = 0; k < 16; k++) x_q[k] <= x[k*W +: W];
      for (int unsigned k = 0; k < 2; k++)  s_q[k] <= s[k*W +: W];
      for (int unsigned k = 0; k < 8; k++)  c_q[k] <= c[k*W +: W];
    end
    if (wr) r[cur.dst] <= res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y0        <= '0;
      y1        <= '0;
      ovf       <= 1'b0;
      op_cnt    <= '0;
      cyc       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          state    <= ST_LOAD;
          in_ready <= 1'b0;
          ovf      <= 1'b0;
        end
        ST_LOAD: begin
          op_cnt <= 5'd1;
          cyc    <= '0;
          state  <= ST_EXEC;
        end
        ST_EXEC: if (wr) begin
          cyc <= '0;
          ovf <= ovf | res_ovf;
          // y1 is written this edge, so it comes straight from the adder.
          if (op_cnt == 5'(N_OPS)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            y0        <= r[N_OPS-2];
            y1        <= res;
          end else begin
            op_cnt <= op_cnt + 5'd1;
          end
        end else begin
          cyc <= cyc + CW'(1);
        end
        ST_DONE: if (out_ready) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arf_sched.sv
// Scoreboard bench for arf_sched: four instances covering SAT and MUL_LAT variants,
// expected results from an arithmetic model of the ARF graph.
module tb_arf_sched;

  localparam int W    = 16;
  localparam int NCFG = 4;

  function automatic int cfg_lat(input int g);
    case (g)
      2:       return 1;
      3:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_sat(input int g);
    return (g == 1) ? 0 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic            in_valid_v  [NCFG];
  logic            in_ready_v  [NCFG];
  logic            out_valid_v [NCFG];
  logic            out_ready_v [NCFG];
  logic            ovf_v       [NCFG];
  logic [16*W-1:0] x_v         [NCFG];
  logic [2*W-1:0]  s_v         [NCFG];
  logic [8*W-1:0]  c_v         [NCFG];
  logic [W-1:0]    y0_v        [NCFG];
  logic [W-1:0]    y1_v        [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    arf_sched #(.W(W), .FRAC(8), .MUL_LAT(cfg_lat(g)), .SAT(cfg_sat(g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .x         (x_v[g]),
      .s         (s_v[g]),
      .c         (c_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .y0        (y0_v[g]),
      .y1        (y1_v[g]),
      .ovf       (ovf_v[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic        ovf;
  } exp_t;

  exp_t exp_q [$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   xs [16];
  int   ss [2];
  int   cs [8];
  bit   m_ovf;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arithmetic: exact integers, floor shift, then fit to 16 bits.
  function automatic longint fit(input longint v, input int sat);
    if (v > 32767 || v < -32768) begin
      m_ovf = 1'b1;
      if (sat != 0) return (v > 0) ? 32767 : -32768;
      return ((v + 32768) & 65535) - 32768;
    end
    return v;
  endfunction

  function automatic longint fmul(input longint a, input longint b, input int sat);
    return fit((a * b) >>> 8, sat);
  endfunction

  function automatic longint fadd(input longint a, input longint b, input int sat);
    return fit(a + b, sat);
  endfunction

  task automatic model(input int sat, output exp_t e);
    longint m [8];
    longint a9, a10, a11, a12, a13, a14, m15, m16, m17, m18, a19, a20;
    longint m21, m22, m23, m24, a25, a26;
    m_ovf = 1'b0;
    for (int j = 0; j < 8; j++) m[j] = fmul(xs[2*j], xs[2*j+1], sat);
    a9  = fadd(m[0], m[1], sat);
    a10 = fadd(m[2], m[3], sat);
    a11 = fadd(m[4], m[5], sat);
    a12 = fadd(m[6], m[7], sat);
    a13 = fadd(a10, ss[0], sat);
    a14 = fadd(a11, ss[1], sat);
    m15 = fmul(a13, cs[0], sat);
    m16 = fmul(a14, cs[1], sat);
    m17 = fmul(a13, cs[2], sat);
    m18 = fmul(a14, cs[3], sat);
    a19 = fadd(m15, m16, sat);
    a20 = fadd(m17, m18, sat);
    m21 = fmul(a19, cs[4], sat);
    m22 = fmul(a20, cs[5], sat);
    m23 = fmul(a19, cs[6], sat);
    m24 = fmul(a20, cs[7], sat);
    a25 = fadd(m21, m22, sat);
    a26 = fadd(m23, m24, sat);
    e.y0  = 16'(fadd(a9, a25, sat));
    e.y1  = 16'(fadd(a12, a26, sat));
    e.ovf = m_ovf;
  endtask

  function automatic int rv();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  task automatic set_const(input int xv, input int sv, input int cv);
    for (int k = 0; k < 16; k++) xs[k] = xv;
    for (int k = 0; k < 2; k++)  ss[k] = sv;
    for (int k = 0; k < 8; k++)  cs[k] = cv;
  endtask

  task automatic set_rand();
    for (int k = 0; k < 16; k++) xs[k] = rv();
    for (int k = 0; k < 2; k++)  ss[k] = rv();
    for (int k = 0; k < 8; k++)  cs[k] = rv();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d);
    for (int k = 0; k < 16; k++) x_v[d][k*W +: W] = 16'(xs[k]);
    for (int k = 0; k < 2; k++)  s_v[d][k*W +: W] = 16'(ss[k]);
    for (int k = 0; k < 8; k++)  c_v[d][k*W +: W] = 16'(cs[k]);
  endtask

  task automatic wait_ready(input int d);
    int t = 0;
    while (!in_ready_v[d] && t < 200) begin
      tick();
      t++;
    end
    check("in_ready_wait", in_ready_v[d], 1);
  endtask

  task automatic run_job(input int d, input int bp, input bit pulse);
    exp_t e;
    int lat;
    wait_ready(d);
    drive(d);
    in_valid_v[d] = 1'b1;
    model(cfg_sat(d), e);
    e.d = d;
    exp_q.push_back(e);
    tick();
    in_valid_v[d] = 1'b0;
    lat = 0;
    while (!out_valid_v[d] && lat < 400) begin
      if (pulse && lat == 8) begin
        in_valid_v[d] = 1'b1;
        x_v[d] = {8{$urandom()}};
        c_v[d] = {4{$urandom()}};
      end
      if (pulse && lat == 12) in_valid_v[d] = 1'b0;
      tick();
      lat++;
    end
    check("latency", lat, 1 + 16 * cfg_lat(d) + 12);
    for (int i = 0; i < bp; i++) begin
      in_valid_v[d] = 1'b1;
      x_v[d] = {8{$urandom()}};
      tick();
      check("bp_out_valid", out_valid_v[d], 1);
      check("bp_in_ready", in_ready_v[d], 0);
      check("bp_y0", y0_v[d], e.y0);
      check("bp_y1", y1_v[d], e.y1);
      check("bp_ovf", ovf_v[d], e.ovf);
    end
    in_valid_v[d]  = 1'b0;
    out_ready_v[d] = 1'b1;
    tick();
    out_ready_v[d] = 1'b0;
    check("post_hs_out_valid", out_valid_v[d], 0);
    check("post_hs_in_ready", in_ready_v[d], 1);
  endtask

  task automatic abort_job(input int d);
    wait_ready(d);
    set_rand();
    drive(d);
    in_valid_v[d] = 1'b1;
    tick();
    in_valid_v[d] = 1'b0;
    repeat (21) tick();
    check("abort_busy", in_ready_v[d], 0);
    #3;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid_v[d], 0);
    check("abort_y0", y0_v[d], 0);
    check("abort_y1", y1_v[d], 0);
    check("abort_ovf", ovf_v[d], 0);
    check("abort_in_ready", in_ready_v[d], 1);
    #2;
    rst = 1'b0;
    tick();
    check("abort_release_in_ready", in_ready_v[d], 1);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NCFG; d++) begin
        if (out_valid_v[d] && out_ready_v[d]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("result_cfg", d, e.d);
            check("y0", y0_v[d], e.y0);
            check("y1", y1_v[d], e.y1);
            check("ovf", ovf_v[d], e.ovf);
          end
        end
      end
    end
  endtask

  task automatic driver();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NCFG; d++) begin
      check("rst_in_ready", in_ready_v[d], 1);
      check("rst_out_valid", out_valid_v[d], 0);
      check("rst_y0", y0_v[d], 0);
      check("rst_y1", y1_v[d], 0);
      check("rst_ovf", ovf_v[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int d = 0; d < NCFG; d++) begin
      set_const(16'sh0100, 0, 16'sh0100);
      run_job(d, 0, 1'b0);
      set_const(0, 0, 16'sh0100);
      xs[0] = -256;
      xs[1] = 256;
      run_job(d, 0, 1'b0);
      set_const(32767, 0, 32767);
      run_job(d, 10, 1'b0);
      set_rand();
      run_job(d, 0, 1'b1);
      abort_job(d);
      set_const(16'sh0100, 0, 16'sh0100);
      run_job(d, 0, 1'b0);
      for (int j = 0; j < 12; j++) begin
        set_rand();
        run_job(d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NCFG; d++) begin
      in_valid_v[d]  = 1'b0;
      out_ready_v[d] = 1'b0;
      x_v[d] = '0;
      s_v[d] = '0;
      c_v[d] = '0;
    end
    fork
      monitor();
      driver();
    join_any
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
